mul_seq_unit: RTL and testbench

- Iterative multiply engine for the multi-cycle ARM core.
- Executes the multiply class that the controller decodes: MUL, UMULL and SMULL. The controller issues a request, and this block returns the low result word and, for long multiplies, the high word for the second register write.
- Issues a stall to the fetch/decode stages while an operation is in flight.
- Uses a radix-2 shift-add datapath with sign correction.

---
 rtl/mul_pkg.sv | 24 ++
 rtl/mul_shift_add_dp.sv | 55 +++++
 rtl/mul_seq_unit.sv | 144 ++++++++++++++
 tb/tb_mul_seq_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential multiply unit.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    MULOP_MUL   = 2'b00,
    MULOP_UMULL = 2'b01,
    MULOP_SMULL = 2'b10,
    MULOP_RSVD  = 2'b11
  } mulop_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SIGN,
    S_DONE
  } state_e;

  function automatic logic is_long_op(input mulop_e op);
    return (op == MULOP_UMULL) || (op == MULOP_SMULL);
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add datapath: accumulator, multiplicand and multiplier shift register.
module mul_shift_add_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               negate,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] prod_next
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    prod_neg = -{hi_q, lo_q};
    if (load) begin
      mcand_d = mcand_in;
      hi_d    = '0;
      lo_d    = mplier_in;
    end else if (step) begin
      // The add carry enters the top bit as {carry, hi, lo} shifts right by one.
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end else if (negate) begin
      hi_d = prod_neg[2*WIDTH-1:WIDTH];
      lo_d = prod_neg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign prod_next = {hi_d, lo_d};

endmodule

// File: rtl/mul_seq_unit.sv
// Iterative MUL/UMULL/SMULL engine: FSM, iteration counter, handshake and result registers.
module mul_seq_unit
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MulOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             IsLong,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [1:0]       MulFlags
);

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  mulop_e           op_q, op_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             is_long_q, is_long_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [1:0]       flags_q, flags_d;

  logic               dp_load, dp_step, dp_negate;
  logic               is_smull;
  logic [WIDTH-1:0]   dp_a, dp_b;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   prod_lo, prod_hi;

  assign is_smull = (mulop_e'(MulOp) == MULOP_SMULL);
  assign dp_a     = (is_smull && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign dp_b     = (is_smull && SrcB[WIDTH-1]) ? -SrcB : SrcB;
  assign prod_lo  = prod_next[WIDTH-1:0];
  assign prod_hi  = prod_next[2*WIDTH-1:WIDTH];

  mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load     (dp_load),
    .step     (dp_step),
    .negate   (dp_negate),
    .mcand_in (dp_a),
    .mplier_in(dp_b),
    .prod_next(prod_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    is_long_d = is_long_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    flags_d   = flags_q;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    dp_negate = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d    = mulop_e'(MulOp);
          neg_d   = is_smull && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          cnt_d   = '0;
          busy_d  = 1'b1;
          dp_load = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(WIDTH - 1)) state_d = S_SIGN;
      end
      S_SIGN: begin
        // Result registers load from the post-negate value so they are valid in the DONE cycle.
        dp_negate = neg_q;
        done_d    = 1'b1;
        is_long_d = is_long_op(op_q);
        res_lo_d  = prod_lo;
        if (is_long_op(op_q)) begin
          res_hi_d = prod_hi;
          flags_d  = {prod_hi[WIDTH-1], (prod_next == '0)};
        end else begin
          res_hi_d = '0;
          flags_d  = {prod_lo[WIDTH-1], (prod_lo == '0)};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= MULOP_MUL;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      is_long_q <= 1'b0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      is_long_q <= is_long_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      flags_q   <= flags_d;
    end
  end

  assign Busy     = busy_q;
  assign Stall    = (Start && (state_q == S_IDLE)) || busy_q;
  assign Done     = done_q;
  assign IsLong   = is_long_q;
  assign ResultLo = res_lo_q;
  assign ResultHi = res_hi_q;
  assign MulFlags = flags_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Self-checking bench for mul_seq_unit: cycle-level reference model plus directed vectors.
module tb_mul_seq_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Start = 1'b0;
  logic [1:0]    MulOp = 2'b00;
  logic [W-1:0]  SrcA = '0;
  logic [W-1:0]  SrcB = '0;
  logic          Busy, Stall, Done, IsLong;
  logic [W-1:0]  ResultLo, ResultHi;
  logic [1:0]    MulFlags;

  int checks = 0;
  int errors = 0;

  mul_seq_unit #(.WIDTH(W), .CNTW(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .MulOp   (MulOp),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .Busy    (Busy),
    .Stall   (Stall),
    .Done    (Done),
    .IsLong  (IsLong),
    .ResultLo(ResultLo),
    .ResultHi(ResultHi),
    .MulFlags(MulFlags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product computed with plain 64-bit arithmetic.
  task automatic ref_mul(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] lo, output logic [W-1:0] hi,
                         output logic lng, output logic [1:0] flg);
    logic [63:0] p;
    logic [63:0] sa, sb;
    if (op == 2'b10) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end
    p   = sa * sb;
    lng = (op == 2'b01) || (op == 2'b10);
    lo  = p[31:0];
    if (lng) begin
      hi  = p[63:32];
      flg = {p[63], (p == 64'd0)};
    end else begin
      hi  = '0;
      flg = {p[31], (p[31:0] == 32'd0)};
    end
  endtask

  // Cycle-level model: accept when idle, results and Done appear W+2 cycles after acceptance.
  logic         m_busy = 1'b0, m_done = 1'b0, m_long = 1'b0;
  logic [W-1:0] m_lo = '0, m_hi = '0;
  logic [1:0]   m_flags = '0;
  int           m_cnt = 0;
  logic [W-1:0] p_lo, p_hi;
  logic         p_long;
  logic [1:0]   p_flags;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_long = 1'b0;
      m_lo = '0; m_hi = '0; m_flags = '0; m_cnt = 0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == W + 2) begin
        m_done = 1'b1;
        m_lo = p_lo; m_hi = p_hi; m_long = p_long; m_flags = p_flags;
      end
    end else if (Start) begin
      m_busy = 1'b1;
      m_cnt  = 1;
      ref_mul(MulOp, SrcA, SrcB, p_lo, p_hi, p_long, p_flags);
    end
  end

  always @(negedge clk) begin
    chk("Busy", {63'b0, Busy}, {63'b0, m_busy});
    chk("Done", {63'b0, Done}, {63'b0, m_done});
    chk("Stall", {63'b0, Stall}, {63'b0, (Start && !m_busy) || m_busy});
    chk("IsLong", {63'b0, IsLong}, {63'b0, m_long});
    chk("ResultLo", {32'b0, ResultLo}, {32'b0, m_lo});
    chk("ResultHi", {32'b0, ResultHi}, {32'b0, m_hi});
    chk("MulFlags", {62'b0, MulFlags}, {62'b0, m_flags});
  end

  task automatic wait_done(output int lat);
    lat = 1;
    while (Done !== 1'b1 && lat < 200) begin
      @(posedge clk); #2;
      lat++;
    end
    chk("done_seen", {63'b0, Done}, 64'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    @(posedge clk); #2;
    Start = 1'b1; MulOp = op; SrcA = a; SrcB = b;
    @(posedge clk); #2;
    Start = 1'b0; MulOp = 2'($urandom); SrcA = $urandom; SrcB = $urandom;
    wait_done(lat);
  endtask

  task automatic check_res(input string tag, input int lat, input logic [W-1:0] lo,
                           input logic [W-1:0] hi, input logic lng, input logic [1:0] flg);
    chk({tag, "_latency"}, 64'(lat), 64'd34);
    chk({tag, "_lo"}, {32'b0, ResultLo}, {32'b0, lo});
    chk({tag, "_hi"}, {32'b0, ResultHi}, {32'b0, hi});
    chk({tag, "_long"}, {63'b0, IsLong}, {63'b0, lng});
    chk({tag, "_flags"}, {62'b0, MulFlags}, {62'b0, flg});
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, lo, hi;
    logic         lng;
    logic [1:0]   flg;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int lat;
    int cyc;
    int ndone;

    vecs[0] = '{2'b00, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0, 2'b00};
    vecs[1] = '{2'b11, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0, 2'b00};
    vecs[2] = '{2'b00, 32'h80000000, 32'd2, 32'd0, 32'd0, 1'b0, 2'b01};
    vecs[3] = '{2'b00, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 2'b10};
    vecs[4] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 2'b10};
    vecs[5] = '{2'b10, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b1, 2'b10};
    vecs[6] = '{2'b10, 32'h80000000, 32'h80000000, 32'd0, 32'h40000000, 1'b1, 2'b00};

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", {63'b0, Busy}, 64'd0);
    chk("rst_done", {63'b0, Done}, 64'd0);
    chk("rst_lo", {32'b0, ResultLo}, 64'd0);
    chk("rst_flags", {62'b0, MulFlags}, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check_res($sformatf("vec%0d", i), lat, vecs[i].lo, vecs[i].hi, vecs[i].lng, vecs[i].flg);
    end

    // Start during RUN and during DONE is ignored; the next cycle's Start is accepted.
    @(posedge clk); #2;
    Start = 1'b1; MulOp = 2'b01; SrcA = 32'h00010000; SrcB = 32'h00010000;
    @(posedge clk); #2;
    Start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(posedge clk); #2; cyc++; end
    Start = 1'b1; MulOp = 2'b10; SrcA = 32'hFFFFFFFF; SrcB = 32'd5;
    chk("stall_in_run", {63'b0, Stall}, 64'd1);
    @(posedge clk); #2;
    Start = 1'b0;
    cyc++;
    while (Done !== 1'b1 && cyc < 200) begin @(posedge clk); #2; cyc++; end
    check_res("ign", cyc, 32'd0, 32'd1, 1'b1, 2'b00);
    Start = 1'b1; MulOp = 2'b00; SrcA = 32'd7; SrcB = 32'd9;
    @(posedge clk); #2;
    chk("after_done_busy", {63'b0, Busy}, 64'd0);
    chk("after_done_stall", {63'b0, Stall}, 64'd1);
    chk("after_done_hold_hi", {32'b0, ResultHi}, 64'd1);
    @(posedge clk); #2;
    Start = 1'b0;
    chk("accept_busy", {63'b0, Busy}, 64'd1);
    chk("accept_hold_hi", {32'b0, ResultHi}, 64'd1);
    wait_done(lat);
    check_res("next", lat, 32'd63, 32'd0, 1'b0, 2'b00);

    for (int i = 4; i < 7; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check_res($sformatf("vec%0d", i), lat, vecs[i].lo, vecs[i].hi, vecs[i].lng, vecs[i].flg);
    end

    // Reset at cycle 15 of a UMULL aborts it with no Done.
    @(posedge clk); #2;
    Start = 1'b1; MulOp = 2'b01; SrcA = 32'h12345678; SrcB = 32'h9ABCDEF0;
    @(posedge clk); #2;
    Start = 1'b0;
    cyc = 1;
    while (cyc < 15) begin @(posedge clk); #2; cyc++; end
    reset = 1'b0;
    #1;
    chk("abort_busy", {63'b0, Busy}, 64'd0);
    chk("abort_stall", {63'b0, Stall}, 64'd0);
    chk("abort_long", {63'b0, IsLong}, 64'd0);
    chk("abort_lo", {32'b0, ResultLo}, 64'd0);
    chk("abort_hi", {32'b0, ResultHi}, 64'd0);
    chk("abort_flags", {62'b0, MulFlags}, 64'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #2;
      if (Done === 1'b1) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    run_op(2'b00, 32'd0, 32'd5, lat);
    check_res("zero", lat, 32'd0, 32'd0, 1'b0, 2'b01);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
